// File: rtl/mv_avg_level_detect.sv
// mv_avg_level_detect
//   Magnitude estimate and debounced level detector for the averaged I/Q pair.
//   Magnitude uses alpha-max-beta-min (max + min/2) over a 2-stage pipeline.
//   A hysteresis/hold FSM turns it into a signal-present level plus
//   one-cycle rise/fall event pulses.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   data_in0/1         signed averaged I / Q samples
//   data_in_valid      sample strobe, may be sparse or back-to-back
//   thresh_high/low    rise threshold (>=) / fall threshold (<), unsigned
//   rise_hold/fall_hold consecutive qualifying samples to assert/deassert
//   mag_out, mag_valid magnitude estimate and its strobe
//   level_det          debounced signal-present level
//   rise_pulse/fall_pulse one-cycle pulses on level_det edges
module mv_avg_level_detect #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic signed [DATA_WIDTH-1:0]  data_in0,
    input  logic signed [DATA_WIDTH-1:0]  data_in1,
    input  logic                          data_in_valid,
    input  logic        [DATA_WIDTH:0]    thresh_high,
    input  logic        [DATA_WIDTH:0]    thresh_low,
    input  logic        [COUNT_WIDTH-1:0] rise_hold,
    input  logic        [COUNT_WIDTH-1:0] fall_hold,
    output logic        [DATA_WIDTH:0]    mag_out,
    output logic                          mag_valid,
    output logic                          level_det,
    output logic                          rise_pulse,
    output logic                          fall_pulse
);

    localparam int unsigned MagWidth = DATA_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRise, StActive, StFall} state_e;

    // Stage 1: absolute values. Negating the most negative code wraps to
    // 2^(DATA_WIDTH-1), which is the correct unsigned magnitude.
    logic [DATA_WIDTH-1:0] abs0, abs1;
    logic [DATA_WIDTH-1:0] a0_q, a1_q;
    logic                  s1_valid_q;

    assign abs0 = data_in0[DATA_WIDTH-1] ? $unsigned(-data_in0) : $unsigned(data_in0);
    assign abs1 = data_in1[DATA_WIDTH-1] ? $unsigned(-data_in1) : $unsigned(data_in1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a0_q       <= '0;
            a1_q       <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= data_in_valid;
            if (data_in_valid) begin
                a0_q <= abs0;
                a1_q <= abs1;
            end
        end
    end

    // Stage 2: max + min/2; result fits MagWidth bits without overflow.
    logic [DATA_WIDTH-1:0] mx, mn;
    logic [DATA_WIDTH:0]   mag_d;
    logic [DATA_WIDTH:0]   mag_q;
    logic                  mag_valid_q;

    always_comb begin
        mx = a0_q;
        mn = a1_q;
        if (a1_q > a0_q) begin
            mx = a1_q;
            mn = a0_q;
        end
        mag_d = MagWidth'(mx) + MagWidth'(mn >> 1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mag_q       <= '0;
            mag_valid_q <= 1'b0;
        end else begin
            mag_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                mag_q <= mag_d;
            end
        end
    end

    assign mag_out   = mag_q;
    assign mag_valid = mag_valid_q;

    // Hysteresis/hold FSM, evaluated only on mag_valid cycles.
    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] hr, hf;
    logic [COUNT_WIDTH-1:0] cnt_sat_inc;
    logic [COUNT_WIDTH:0]   cnt_next;
    logic                   qual_hi, qual_lo;
    logic                   rise_done, fall_done;
    logic                   level_q, rise_q, fall_q;
    logic                   level_d, rise_d, fall_d;

    assign hr          = (rise_hold == '0) ? COUNT_WIDTH'(1) : rise_hold;
    assign hf          = (fall_hold == '0) ? COUNT_WIDTH'(1) : fall_hold;
    assign qual_hi     = (mag_q >= thresh_high);
    assign qual_lo     = (mag_q < thresh_low);
    assign cnt_next    = {1'b0, cnt_q} + (COUNT_WIDTH + 1)'(1);
    assign cnt_sat_inc = (&cnt_q) ? cnt_q : cnt_q + COUNT_WIDTH'(1);
    // >= so a hold shortened below the current count completes next sample.
    assign rise_done   = (cnt_next >= {1'b0, hr});
    assign fall_done   = (cnt_next >= {1'b0, hf});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (mag_valid_q) begin
            unique case (state_q)
                StIdle: begin
                    if (qual_hi) begin
                        if (hr == COUNT_WIDTH'(1)) begin
                            state_d = StActive;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = StRise;
                            cnt_d   = COUNT_WIDTH'(1);
                        end
                    end
                end
                StRise: begin
                    if (!qual_hi) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (rise_done) begin
                        state_d = StActive;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_sat_inc;
                    end
                end
                StActive: begin
                    if (qual_lo) begin
                        if (hf == COUNT_WIDTH'(1)) begin
                            state_d = StIdle;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = StFall;
                            cnt_d   = COUNT_WIDTH'(1);
                        end
                    end
                end
                StFall: begin
                    if (!qual_lo) begin
                        state_d = StActive;
                        cnt_d   = '0;
                    end else if (fall_done) begin
                        state_d = StIdle;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_sat_inc;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
        level_d = (state_d == StActive) || (state_d == StFall);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_det  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_mv_avg_level_detect.sv
module tb_mv_avg_level_detect;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;

    logic                 clk;
    logic                 rstn;
    logic signed [DW-1:0] data_in0;
    logic signed [DW-1:0] data_in1;
    logic                 data_in_valid;
    logic [DW:0]          thresh_high;
    logic [DW:0]          thresh_low;
    logic [CW-1:0]        rise_hold;
    logic [CW-1:0]        fall_hold;
    logic [DW:0]          mag_out;
    logic                 mag_valid;
    logic                 level_det;
    logic                 rise_pulse;
    logic                 fall_pulse;

    int checks = 0;
    int errors = 0;

    // Observations captured by send() at cycles n+1 and n+2.
    logic        obs_mv1;
    logic        obs_mv2;
    logic [DW:0] obs_mag;

    mv_avg_level_detect #(
        .DATA_WIDTH  (DW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .data_in0      (data_in0),
        .data_in1      (data_in1),
        .data_in_valid (data_in_valid),
        .thresh_high   (thresh_high),
        .thresh_low    (thresh_low),
        .rise_hold     (rise_hold),
        .fall_hold     (fall_hold),
        .mag_out       (mag_out),
        .mag_valid     (mag_valid),
        .level_det     (level_det),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // One strobe at cycle n; returns at the start of cycle n+3.
    task automatic send(input int i, input int q);
        @(negedge clk);
        data_in0      = DW'(i);
        data_in1      = DW'(q);
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        obs_mv1       = mag_valid;
        @(negedge clk);
        obs_mv2 = mag_valid;
        obs_mag = mag_out;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn          = 1'b0;
        data_in0      = '0;
        data_in1      = '0;
        data_in_valid = 1'b0;
        thresh_high   = 17'd100000;
        thresh_low    = 17'd0;
        rise_hold     = 16'd1;
        fall_hold     = 16'd1;
        idle(3);
        checks++; if (mag_out !== 17'd0) begin errors++; $display("FAIL reset_mag_out: got %0d want 0", mag_out); end
        checks++; if (mag_valid !== 1'b0) begin errors++; $display("FAIL reset_mag_valid: got %b want 0", mag_valid); end
        checks++; if (level_det !== 1'b0) begin errors++; $display("FAIL reset_level: got %b want 0", level_det); end
        checks++; if ({rise_pulse, fall_pulse} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {rise_pulse, fall_pulse}); end
        rstn = 1'b1;
        idle(2);
    endtask

    task automatic test_magnitude();
        send(3000, -4000);
        checks++; if (obs_mv1 !== 1'b0) begin errors++; $display("FAIL mag_latency_early: mag_valid at n+1 got %b want 0", obs_mv1); end
        checks++; if (obs_mv2 !== 1'b1) begin errors++; $display("FAIL mag_latency: mag_valid at n+2 got %b want 1", obs_mv2); end
        checks++; if (obs_mag !== 17'd5500) begin errors++; $display("FAIL mag_3000_m4000: got %0d want 5500", obs_mag); end
        checks++; if (mag_valid !== 1'b0) begin errors++; $display("FAIL mag_valid_width: got %b want 0 at n+3", mag_valid); end
        checks++; if (mag_out !== 17'd5500) begin errors++; $display("FAIL mag_hold: got %0d want 5500", mag_out); end
        send(-32768, -32768);
        checks++; if (obs_mag !== 17'd49152) begin errors++; $display("FAIL mag_most_negative: got %0d want 49152", obs_mag); end
        send(0, 0);
        checks++; if (obs_mag !== 17'd0) begin errors++; $display("FAIL mag_zero: got %0d want 0", obs_mag); end
        checks++; if (level_det !== 1'b0) begin errors++; $display("FAIL mag_no_level: got %b want 0", level_det); end
    endtask

    task automatic test_rise_debounce();
        int mags[6] = '{1200, 1200, 900, 1200, 1200, 1200};
        thresh_high = 17'd1000;
        thresh_low  = 17'd0;
        rise_hold   = 16'd3;
        for (int k = 0; k < 5; k++) begin
            send(mags[k], 0);
            checks++; if (level_det !== 1'b0 || rise_pulse !== 1'b0) begin
                errors++; $display("FAIL rise_early_%0d: level=%b pulse=%b want 0 0", k, level_det, rise_pulse);
            end
        end
        send(mags[5], 0);
        checks++; if (level_det !== 1'b1) begin errors++; $display("FAIL rise_level: got %b want 1", level_det); end
        checks++; if (rise_pulse !== 1'b1) begin errors++; $display("FAIL rise_pulse: got %b want 1", rise_pulse); end
        @(negedge clk);
        checks++; if (rise_pulse !== 1'b0 || level_det !== 1'b1) begin
            errors++; $display("FAIL rise_pulse_width: pulse=%b level=%b want 0 1", rise_pulse, level_det);
        end
    endtask

    task automatic test_fall_debounce();
        int mags[4] = '{400, 600, 400, 400};
        thresh_low = 17'd500;
        fall_hold  = 16'd2;
        for (int k = 0; k < 3; k++) begin
            send(mags[k], 0);
            checks++; if (level_det !== 1'b1 || fall_pulse !== 1'b0) begin
                errors++; $display("FAIL fall_early_%0d: level=%b pulse=%b want 1 0", k, level_det, fall_pulse);
            end
        end
        send(mags[3], 0);
        checks++; if (level_det !== 1'b0) begin errors++; $display("FAIL fall_level: got %b want 0", level_det); end
        checks++; if (fall_pulse !== 1'b1 || rise_pulse !== 1'b0) begin
            errors++; $display("FAIL fall_pulse: fall=%b rise=%b want 1 0", fall_pulse, rise_pulse);
        end
        @(negedge clk);
        checks++; if (fall_pulse !== 1'b0) begin errors++; $display("FAIL fall_pulse_width: got %b want 0", fall_pulse); end
    endtask

    task automatic test_hold_zero();
        thresh_high = 17'd1000;
        thresh_low  = 17'd500;
        rise_hold   = 16'd0;
        fall_hold   = 16'd0;
        send(1200, 0);
        checks++; if (level_det !== 1'b1 || rise_pulse !== 1'b1) begin
            errors++; $display("FAIL hold0_rise: level=%b pulse=%b want 1 1", level_det, rise_pulse);
        end
        send(400, 0);
        checks++; if (level_det !== 1'b0 || fall_pulse !== 1'b1) begin
            errors++; $display("FAIL hold0_fall: level=%b pulse=%b want 0 1", level_det, fall_pulse);
        end
    endtask

    task automatic test_sparse();
        rise_hold = 16'd2;
        send(1200, 0);
        idle(5);
        checks++; if (level_det !== 1'b0) begin errors++; $display("FAIL sparse_first: level=%b want 0", level_det); end
        send(1200, 0);
        checks++; if (level_det !== 1'b1 || rise_pulse !== 1'b1) begin
            errors++; $display("FAIL sparse_second: level=%b pulse=%b want 1 1", level_det, rise_pulse);
        end
        fall_hold = 16'd0;
        send(0, 0);
        checks++; if (level_det !== 1'b0) begin errors++; $display("FAIL sparse_return: level=%b want 0", level_det); end
    endtask

    task automatic test_reduced_hold();
        rise_hold = 16'd4;
        for (int k = 0; k < 3; k++) send(1200, 0);
        checks++; if (level_det !== 1'b0) begin errors++; $display("FAIL reduce_before: level=%b want 0", level_det); end
        rise_hold = 16'd2;
        send(1200, 0);
        checks++; if (level_det !== 1'b1 || rise_pulse !== 1'b1) begin
            errors++; $display("FAIL reduce_complete: level=%b pulse=%b want 1 1", level_det, rise_pulse);
        end
        send(0, 0);
        checks++; if (level_det !== 1'b0) begin errors++; $display("FAIL reduce_return: level=%b want 0", level_det); end
    endtask

    task automatic test_async_reset();
        rise_hold = 16'd1;
        send(1200, 0);
        fall_hold = 16'd3;
        send(400, 0);
        checks++; if (level_det !== 1'b1) begin errors++; $display("FAIL ar_in_fall: level=%b want 1", level_det); end
        // In-flight sample, then reset between clock edges.
        @(negedge clk);
        data_in0      = 16'sd1200;
        data_in1      = 16'sd0;
        data_in_valid = 1'b1;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (level_det !== 1'b0) begin errors++; $display("FAIL ar_level: got %b want 0", level_det); end
        checks++; if (mag_out !== 17'd0) begin errors++; $display("FAIL ar_mag_out: got %0d want 0", mag_out); end
        checks++; if (mag_valid !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
            errors++; $display("FAIL ar_strobes: mv=%b rise=%b fall=%b want 0 0 0", mag_valid, rise_pulse, fall_pulse);
        end
        data_in_valid = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(3);
        checks++; if (mag_valid !== 1'b0 || mag_out !== 17'd0) begin
            errors++; $display("FAIL ar_inflight_dropped: mv=%b mag=%0d want 0 0", mag_valid, mag_out);
        end
        rise_hold = 16'd2;
        send(1200, 0);
        checks++; if (level_det !== 1'b0) begin errors++; $display("FAIL ar_restart_idle: level=%b want 0", level_det); end
        send(1200, 0);
        checks++; if (level_det !== 1'b1 || rise_pulse !== 1'b1) begin
            errors++; $display("FAIL ar_restart_rise: level=%b pulse=%b want 1 1", level_det, rise_pulse);
        end
    endtask

    task automatic test_back_to_back();
        thresh_low = 17'd0;
        @(negedge clk);
        data_in0 = 16'sd3000; data_in1 = -16'sd4000; data_in_valid = 1'b1;
        @(negedge clk);
        data_in0 = -16'sd32768; data_in1 = -16'sd32768;
        @(negedge clk);
        data_in0 = 16'sd100; data_in1 = 16'sd7;
        checks++; if (mag_valid !== 1'b1 || mag_out !== 17'd5500) begin
            errors++; $display("FAIL b2b_0: mv=%b mag=%0d want 1 5500", mag_valid, mag_out);
        end
        @(negedge clk);
        data_in_valid = 1'b0;
        checks++; if (mag_valid !== 1'b1 || mag_out !== 17'd49152) begin
            errors++; $display("FAIL b2b_1: mv=%b mag=%0d want 1 49152", mag_valid, mag_out);
        end
        @(negedge clk);
        checks++; if (mag_valid !== 1'b1 || mag_out !== 17'd103) begin
            errors++; $display("FAIL b2b_2: mv=%b mag=%0d want 1 103", mag_valid, mag_out);
        end
        @(negedge clk);
        checks++; if (mag_valid !== 1'b0 || level_det !== 1'b1) begin
            errors++; $display("FAIL b2b_end: mv=%b level=%b want 0 1", mag_valid, level_det);
        end
    endtask

    initial begin
        test_reset();
        test_magnitude();
        test_rise_debounce();
        test_fall_debounce();
        test_hold_zero();
        test_sparse();
        test_reduced_hold();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mv_avg_level_detect.md
Name: mv_avg_level_detect

Overview:
Downstream consumer of the dual-channel moving-average stage in rx_intf. It takes the averaged I/Q pair (channel 0 = I, channel 1 = Q) and computes an alpha-max-beta-min magnitude estimate in a 2-stage pipeline. A hysteresis/hold FSM then turns that estimate into a debounced signal-present level plus one-cycle rise/fall event pulses, for gating and status logic in rx_intf.

Parameters:
DATA_WIDTH, 16, width of each signed input channel (both channels equal)
COUNT_WIDTH, 16, width of hold counters and hold-length inputs

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
data_in0  input  DATA_WIDTH  signed averaged I sample
data_in1  input  DATA_WIDTH  signed averaged Q sample
data_in_valid  input  1  sample strobe, one cycle per sample, may be sparse
thresh_high  input  DATA_WIDTH+1  unsigned rise threshold, compared with >=
thresh_low  input  DATA_WIDTH+1  unsigned fall threshold, compared with <
rise_hold  input  COUNT_WIDTH  consecutive qualifying samples needed to assert
fall_hold  input  COUNT_WIDTH  consecutive qualifying samples needed to deassert
mag_out  output  DATA_WIDTH+1  unsigned magnitude estimate
mag_valid  output  1  strobe for mag_out
level_det  output  1  debounced signal-present level
rise_pulse  output  1  one-cycle pulse on 0->1 of level_det
fall_pulse  output  1  one-cycle pulse on 1->0 of level_det

Behaviour:
- Reset: asynchronous, active-low. All registers clear immediately: mag_out=0, mag_valid=0, level_det=0, rise_pulse=0, fall_pulse=0, state=IDLE, counter=0, pipeline valids=0. Deassertion mid-stream discards in-flight samples; operation restarts from IDLE.
- Stage 1 (registered on data_in_valid): a0=|data_in0|, a1=|data_in1| as DATA_WIDTH-bit unsigned. |-2^(DATA_WIDTH-1)| = 2^(DATA_WIDTH-1), no saturation. s1_valid <= data_in_valid.
- Stage 2: mag_out <= max(a0,a1) + (min(a0,a1)>>1), DATA_WIDTH+1 bits, no overflow (max 1.5*2^(DATA_WIDTH-1)). mag_valid <= s1_valid. mag_out holds its value between strobes.
- Latency: data_in_valid at cycle n gives mag_valid at n+2, and level_det/pulse updates at n+3. Back-to-back valids are supported at full rate.
- FSM advances only on cycles with mag_valid=1. It holds on all other cycles. Effective hold Hr=max(rise_hold,1), Hf=max(fall_hold,1). A qualifying sample is mag_out>=thresh_high in IDLE/RISE and mag_out<thresh_low in ACTIVE/FALL.
  - IDLE (level 0): qualifying and Hr=1 -> ACTIVE, with rise_pulse. Qualifying and Hr>1 -> RISE, cnt=1. Otherwise stay.
  - RISE (level 0): qualifying and cnt+1==Hr -> ACTIVE, with rise_pulse and cnt=0. Qualifying otherwise -> cnt+1. Non-qualifying -> IDLE, cnt=0.
  - ACTIVE (level 1): qualifying and Hf=1 -> IDLE, with fall_pulse. Qualifying and Hf>1 -> FALL, cnt=1. Otherwise stay.
  - FALL (level 1): qualifying and cnt+1==Hf -> IDLE, with fall_pulse and cnt=0. Qualifying otherwise -> cnt+1. Non-qualifying -> ACTIVE, cnt=0.
- Pulses are registered and last exactly one cycle. They coincide with the level_det edge. rise_pulse and fall_pulse are never both high.
- Thresholds and hold lengths are sampled live on each evaluated sample and are not latched. Changing them mid-count applies from the next evaluated sample. If cnt is already >= a newly reduced hold, the next qualifying sample completes the transition (compare with >=).
- thresh_low > thresh_high is legal; behaviour follows the rules above.
- Counter saturates at 2^COUNT_WIDTH-1 and never wraps.

Test Plan:
- Magnitude: I=3000, Q=-4000 single strobe -> mag_out=5500, mag_valid high exactly 2 cycles after the strobe. I=Q=-32768 -> mag_out=49152. I=0, Q=0 -> 0.
- Rise debounce: thresh_high=1000, rise_hold=3, samples mag 1200,1200,900,1200,1200,1200 -> level_det rises only after the 6th sample (3 cycles after its strobe), single rise_pulse.
- Fall debounce: thresh_low=500, fall_hold=2, from ACTIVE feed 400,600,400,400 -> fall_pulse after the 4th sample, level_det=0.
- Hold=0: rise_hold=0, fall_hold=0 -> a single qualifying sample toggles level_det, with one pulse each direction.
- Sparse valid: gaps of 5 idle cycles between strobes with rise_hold=2 -> counting is unaffected by gaps; transition occurs on the 2nd qualifying strobe.
- Async reset: assert rstn=0 mid-FALL between clock edges -> all outputs 0 immediately, without waiting for a clock. After release, the first sample evaluates from IDLE.
